// File: rtl/sw_debounce_pkg.sv
// Shared types and defaults for the board switch debouncer that drives the
// clock-select bus.
package clocking_pkg;

  // Per-channel debounce state.
  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } sw_state_e;

  localparam int SW_SYNC_STAGES_DEF     = 2;
  localparam int SW_DEBOUNCE_CYCLES_DEF = 50000;

  // Width of the debounce counter: $clog2 of the cycle count, never below 1 bit.
  function automatic int sw_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_debounce_channel.sv
// One switch channel: synchroniser chain, debounce counter and two-state FSM.
// Optional macro SW_DEBOUNCE_CHANGE_PULSE_EN adds the registered change pulse.
module sw_debounce_channel
  import clocking_pkg::*;
#(
  parameter int   SYNC_STAGES     = SW_SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEF,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_out
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
  ,
  output logic sw_changed
`endif
);

  localparam int                CW       = sw_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]     CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{RESET_VAL}};

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sw_debounce_channel: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("sw_debounce_channel: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sw_sync;
  logic                   mismatch;
  sw_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   take;

  assign sw_sync  = sync_q[SYNC_STAGES-1];
  assign mismatch = (sw_sync != sw_out);

  // Synchroniser chain: the raw pin enters at bit 0, sw_sync leaves the top bit.
  // NOTE: every clocked process uses <= so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= SYNC_RST;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
  end

  // Next-state logic: count consecutive mismatching cycles, accept on the last.
  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (mismatch) begin
          if (DEBOUNCE_CYCLES == 1) begin
            take = 1'b1;
          end else begin
            state_d = PENDING;
            cnt_d   = CW'(1);
          end
        end
      end
      PENDING: begin
        if (!mismatch) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          take    = 1'b1;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and debounced output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      sw_out  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) sw_out <= sw_sync;
    end
  end

`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
  // Change pulse: set on the same edge sw_out toggles, so it is high for the
  // one cycle that follows.
  always_ff @(posedge clk) begin
    if (rst) sw_changed <= 1'b0;
    else     sw_changed <= take;
  end
`endif

endmodule

// File: rtl/sw_debounce.sv
// Debounced slide-switch bus for the clock-select network: one independent
// channel per switch. Optional macro SW_DEBOUNCE_CHANGE_PULSE_EN exposes the
// per-channel sw_changed pulse.
module sw_debounce
  import clocking_pkg::*;
#(
  parameter int                NUM_SW          = 2,
  parameter int                SYNC_STAGES     = SW_SYNC_STAGES_DEF,
  parameter int                DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEF,
  parameter logic [NUM_SW-1:0] SW_RESET_VAL    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_out
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
  ,
  output logic [NUM_SW-1:0] sw_changed
`endif
);

  // Replicate one debounce channel per switch bit.
  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    sw_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (SW_RESET_VAL[i])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sw_raw    (sw_raw[i]),
      .sw_out    (sw_out[i])
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
      ,
      .sw_changed(sw_changed[i])
`endif
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: directed scenarios plus randomized
// switch activity, compared every cycle against a history-window model.
module tb_sw_debounce;

  localparam int NUM_SW = 2;
  localparam int SYNC   = 2;
  localparam int DEB    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_SW-1:0] sw_raw;
  logic [NUM_SW-1:0] sw_out;
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
  logic [NUM_SW-1:0] sw_changed;
`endif

  int checks = 0;
  int errors = 0;

  sw_debounce #(
    .NUM_SW         (NUM_SW),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .SW_RESET_VAL   ('0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_out    (sw_out)
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
    ,
    .sw_changed(sw_changed)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the synchroniser is a plain delay line; the output flips
  // once the last DEB synchronised samples (since reset or the last flip) all
  // disagree with it.
  logic [NUM_SW-1:0] m_stage [SYNC];
  logic [NUM_SW-1:0] hist [$];
  int                start [NUM_SW];
  logic [NUM_SW-1:0] m_out;
  logic [NUM_SW-1:0] m_chg;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [NUM_SW-1:0] prior;
    bit                all_diff;
    if (rst) begin
      for (int k = 0; k < SYNC; k++) m_stage[k] = '0;
      m_out = '0;
      m_chg = '0;
      hist.delete();
      for (int i = 0; i < NUM_SW; i++) start[i] = 0;
    end else begin
      prior = m_stage[SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) m_stage[k] = m_stage[k-1];
      m_stage[0] = sw_raw;
      hist.push_back(prior);
      m_chg = '0;
      for (int i = 0; i < NUM_SW; i++) begin
        if (hist.size() - start[i] >= DEB) begin
          all_diff = 1'b1;
          for (int j = 1; j <= DEB; j++)
            if (hist[hist.size() - j][i] == m_out[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_out[i] = ~m_out[i];
            m_chg[i] = 1'b1;
            start[i] = hist.size();
          end
        end
      end
    end
  endtask

  // One clock edge: advance the model, then compare just after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("sw_out", sw_out, m_out);
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
    check("sw_changed", sw_changed, m_chg);
`endif
  endtask

  task automatic settle(input logic [NUM_SW-1:0] val, input int n);
    sw_raw = val;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst    = 1'b1;
    sw_raw = 2'b11;

    // Reset held with switches high: outputs stay at reset value.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_out", sw_out, 2'b00);
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
      check("rst_chg", sw_changed, 2'b00);
`endif
    end
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 9)  check("rel_e9", sw_out, 2'b00);
      if (e == 10) check("rel_e10", sw_out, 2'b11);
    end

    // Clean rising edge on bit 0.
    settle(2'b00, 12);
    sw_raw = 2'b01;
    for (int e = 1; e <= 11; e++) begin
      step();
      if (e == 9)  check("clean_e9", sw_out, 2'b00);
      if (e == 10) check("clean_e10", sw_out, 2'b01);
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
      if (e == 9)  check("clean_chg_e9", sw_changed, 2'b00);
      if (e == 10) check("clean_chg_e10", sw_changed, 2'b01);
      if (e == 11) check("clean_chg_e11", sw_changed, 2'b00);
`endif
    end

    // Bounce on bit 1: seven high cycles are one short of acceptance.
    settle(2'b11, 7);
    sw_raw = 2'b01;
    for (int e = 1; e <= 12; e++) begin
      step();
      check("bounce_out1", {7'd0, sw_out[1]}, 8'd0);
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
      check("bounce_chg1", {7'd0, sw_changed[1]}, 8'd0);
`endif
    end
    sw_raw = 2'b11;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 9)  check("steady_e9", {7'd0, sw_out[1]}, 8'd0);
      if (e == 10) check("steady_e10", {7'd0, sw_out[1]}, 8'd1);
    end

    // Simultaneous change on both channels.
    settle(2'b00, 12);
    sw_raw = 2'b11;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 9)  check("simul_e9", sw_out, 2'b00);
      if (e == 10) check("simul_e10", sw_out, 2'b11);
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
      if (e == 10) check("simul_chg", sw_changed, 2'b11);
`endif
    end

    // Reset in mid-count (counter at 5 after edge 7), input held high.
    settle(2'b00, 12);
    settle(2'b11, 7);
    rst = 1'b1;
    step();
    check("midrst_out", sw_out, 2'b00);
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 9)  check("midrst_e9", sw_out, 2'b00);
      if (e == 10) check("midrst_e10", sw_out, 2'b11);
    end

    // Randomized switch activity with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(15, 0) == 0) sw_raw[$urandom_range(NUM_SW - 1, 0)] ^= 1'b1;
      rst = ($urandom_range(199, 0) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Synchronises and debounces the raw board slide switches and drives the stable `sw_in` select bus of the clocking network, whose BUFGMUX selects must never see metastable or bouncing levels. Each switch has its own synchroniser chain, debounce counter and two-state FSM. An optional one-cycle change pulse tells downstream logic that a clock-select bit has just moved.

## Interface
- `NUM_SW`, 2: number of switch channels
- `SYNC_STAGES`, 2: synchroniser flops per channel, minimum 2
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required before a change is accepted, minimum 1
- `SW_RESET_VAL`, '0: reset value of the synchroniser chain and `sw_out` (NUM_SW bits)

- `clk`  in  1  system clock, the same clock that feeds the clock wizard
- `rst`  in  1  synchronous reset, active-high
- `sw_raw`  in  NUM_SW  asynchronous switch pins
- `sw_out`  out  NUM_SW  debounced switch levels, feeds `sw_in`
- `sw_changed`  out  NUM_SW  one-cycle pulse per channel when `sw_out` toggles; present only with the macro

## Operation
- Synchroniser: per bit, a `SYNC_STAGES` flop chain. `sw_sync` is the last stage.
- Per-channel FSM:
  - STABLE: `sw_sync == sw_out`; counter held at 0.
  - PENDING: `sw_sync != sw_out`; counter increments each cycle.
- Transitions:
  - STABLE→PENDING when `sw_sync != sw_out`; counter 0→1 on that edge.
  - PENDING→STABLE with no output change when `sw_sync` returns to `sw_out`; counter cleared to 0 on that edge.
  - PENDING→STABLE with output change when `sw_sync != sw_out` and counter == DEBOUNCE_CYCLES-1. On that edge `sw_out` <= `sw_sync` and counter <= 0.
- Counter:
  - Unsigned, width `$clog2(DEBOUNCE_CYCLES)`, with a floor of 1 bit.
  - Never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- DEBOUNCE_CYCLES == 1: output follows `sw_sync` one cycle later, with no filtering.
- Channels are fully independent. Simultaneous changes on several channels update on the same edge if their counts complete together.
- Reset, from any state including mid-count:
  - Synchroniser chain, `sw_out` <= SW_RESET_VAL.
  - Counters <= 0; FSM <= STABLE.
  - `sw_changed` <= 0.
  - A switch held away from SW_RESET_VAL through reset is re-debounced from zero after reset drops.

## Timing
- Reference point: raw change is set up before edge 1.
  - `sw_sync` changes at edge SYNC_STAGES.
  - `sw_out` changes at edge SYNC_STAGES + DEBOUNCE_CYCLES.
- Any return of `sw_sync` to `sw_out` before that edge restarts the full count on the next mismatch.
- `sw_changed[i]` is registered. It is high for exactly the one cycle following the edge on which `sw_out[i]` toggles.
- Outputs are flop-driven, with no combinational path from `sw_raw`.
- Reset takes effect on the first `clk` edge with `rst` high.

## Configuration
- `SW_DEBOUNCE_CHANGE_PULSE_EN`
  - Defined: the `sw_changed` port and its register exist, behaving as above.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `clocking_pkg` holds:
  - `sw_state_e` (STABLE, PENDING), 1-bit enum
  - Default constants `SW_SYNC_STAGES_DEF` = 2 and `SW_DEBOUNCE_CYCLES_DEF` = 50000
- Sub-module `sw_debounce_channel`: one synchroniser, counter and FSM. Instantiated NUM_SW times via generate.
- Top level handles only replication and macro-gated port wiring.

## Test plan
Common settings: NUM_SW=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, SW_RESET_VAL=0.
- Reset: assert `rst` 3 cycles with `sw_raw`=2'b11 -> `sw_out`=2'b00 and `sw_changed`=0 throughout reset. After release, `sw_out`=2'b11 at edge 10 counting from the first edge after release.
- Clean edge: `sw_raw[0]` 0→1 before edge 1 -> `sw_out[0]`=1 at edge 10. `sw_changed[0]` high for exactly the cycle after edge 10 (macro defined).
- Bounce: `sw_raw[1]` high for 7 cycles then low -> `sw_out[1]` stays 0 and no pulse. A subsequent steady high gives `sw_out[1]`=1 exactly 10 edges after it begins.
- Simultaneous: both bits 0→1 on the same cycle -> both `sw_out` bits and both pulses on the same edge.
- Mid-count reset: `rst` pulsed at count 5 -> counter 0, `sw_out`=0. With input still high, update at edge 10 counting from the first edge after release.
- Macro undefined: the same stimulus as the clean-edge case gives identical `sw_out` timing, and `sw_changed` does not exist.
